reflet_vga_rect_fill: RTL and testbench

//  Command-driven rectangle filler sitting directly upstream of reflet_VGA's pixel write port.

---
 rtl/reflet_vga_rect_fill_pkg.sv | 25 ++
 rtl/reflet_vga_rect_fill_pacer.sv | 41 ++++
 rtl/reflet_vga_rect_fill.sv | 175 +++++++++++++++++
 tb/tb_reflet_vga_rect_fill.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reflet_vga_rect_fill_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reflet_vga_rect_fill_pkg
//  Description : Shared dimensions and FSM state encoding for the rectangle
//                filler, kept consistent with the reflet_VGA framebuffer.
//  Revision    : 1.0 - initial release
// ============================================================================
package reflet_vga_rect_fill_pkg;

  // Reduced-resolution framebuffer geometry (bit_reduction 3)
  localparam int c_COLOR_DEPTH = 2;
  localparam int c_H_WIDTH     = 7;
  localparam int c_V_WIDTH     = 6;
  localparam int c_H_MAX       = 80;
  localparam int c_V_MAX       = 60;

  // Filler control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CLIP = 2'd1,
    ST_FILL = 2'd2
  } fill_state_t;

endpackage
`default_nettype wire

// File: rtl/reflet_vga_rect_fill_pacer.sv
`default_nettype none
// ============================================================================
//  Module      : reflet_vga_rect_fill_pacer
//  Description : Reloading down-counter that spaces pixel writes by
//                WRITE_INTERVAL cycles. tick is high whenever the count is 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module reflet_vga_rect_fill_pacer #(
  parameter int WRITE_INTERVAL = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic restart,
  output logic tick
);

  localparam int                c_CW     = (WRITE_INTERVAL > 1) ? $clog2(WRITE_INTERVAL) : 1;
  localparam logic [c_CW-1:0]   c_RELOAD = c_CW'(WRITE_INTERVAL - 1);

  logic [c_CW-1:0] r_count;

  // Count down between writes; reload after each tick, clear on restart
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (restart) begin
      r_count <= '0;
    end else if (enable) begin
      if (r_count == '0) begin
        r_count <= c_RELOAD;
      end else begin
        r_count <= r_count - c_CW'(1);
      end
    end
  end

  assign tick = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/reflet_vga_rect_fill.sv
`default_nettype none
// ============================================================================
//  Module      : reflet_vga_rect_fill
//  Description : Command-driven rectangle filler. Latches one rectangle and
//                colour, clips it to the framebuffer, then emits paced pixel
//                writes in raster order to reflet_VGA's write port.
//  Revision    : 1.0 - initial release
// ============================================================================
module reflet_vga_rect_fill
  import reflet_vga_rect_fill_pkg::*;
#(
  parameter int COLOR_DEPTH    = c_COLOR_DEPTH,
  parameter int H_WIDTH        = c_H_WIDTH,
  parameter int V_WIDTH        = c_V_WIDTH,
  parameter int H_MAX          = c_H_MAX,
  parameter int V_MAX          = c_V_MAX,
  parameter int WRITE_INTERVAL = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [H_WIDTH-1:0]     cmd_x0,
  input  logic [V_WIDTH-1:0]     cmd_y0,
  input  logic [H_WIDTH-1:0]     cmd_x1,
  input  logic [V_WIDTH-1:0]     cmd_y1,
  input  logic [COLOR_DEPTH-1:0] cmd_R,
  input  logic [COLOR_DEPTH-1:0] cmd_G,
  input  logic [COLOR_DEPTH-1:0] cmd_B,
  input  logic                   abort,
  output logic                   busy,
  output logic                   write_en,
  output logic [H_WIDTH-1:0]     h_pixel,
  output logic [V_WIDTH-1:0]     v_pixel,
  output logic [COLOR_DEPTH-1:0] R_out,
  output logic [COLOR_DEPTH-1:0] G_out,
  output logic [COLOR_DEPTH-1:0] B_out
);

  localparam logic [H_WIDTH-1:0] c_H_LAST = H_WIDTH'(H_MAX - 1);
  localparam logic [V_WIDTH-1:0] c_V_LAST = V_WIDTH'(V_MAX - 1);

  fill_state_t            r_state;
  fill_state_t            w_next_state;
  logic                   w_accept;
  logic                   w_tick;

  logic [H_WIDTH-1:0]     r_x0;
  logic [V_WIDTH-1:0]     r_y0;
  logic [H_WIDTH-1:0]     r_x1;     // holds the clipped right edge once in FILL
  logic [V_WIDTH-1:0]     r_y1;     // holds the clipped bottom edge once in FILL
  logic [H_WIDTH-1:0]     r_h;
  logic [V_WIDTH-1:0]     r_v;
  logic [COLOR_DEPTH-1:0] r_red;
  logic [COLOR_DEPTH-1:0] r_grn;
  logic [COLOR_DEPTH-1:0] r_blu;

  logic [H_WIDTH-1:0]     w_x1c;
  logic [V_WIDTH-1:0]     w_y1c;
  logic                   w_empty;
  logic                   w_row_end;
  logic                   w_last;

  // Clip the far corner to the screen; anything left of/above the origin is empty
  assign w_x1c     = (r_x1 > c_H_LAST) ? c_H_LAST : r_x1;
  assign w_y1c     = (r_y1 > c_V_LAST) ? c_V_LAST : r_y1;
  assign w_empty   = (r_x0 > w_x1c) || (r_y0 > w_y1c);
  assign w_row_end = (r_h >= r_x1);
  assign w_last    = w_row_end && (r_v >= r_y1);

  reflet_vga_rect_fill_pacer #(
    .WRITE_INTERVAL (WRITE_INTERVAL)
  ) u_pacer (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (r_state == ST_FILL),
    .restart (r_state == ST_CLIP),
    .tick    (w_tick)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and handshake/strobe decode
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    cmd_ready    = 1'b0;
    busy         = 1'b0;
    write_en     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cmd_ready = !abort;
        if (cmd_valid && !abort) begin
          w_accept     = 1'b1;
          w_next_state = ST_CLIP;
        end
      end
      ST_CLIP: begin
        busy = 1'b1;
        if (abort || w_empty) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_FILL;
        end
      end
      ST_FILL: begin
        busy     = 1'b1;
        write_en = w_tick;
        if (abort || (w_tick && w_last)) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Command latch, clip store and raster-order coordinate stepping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x0  <= '0;
      r_y0  <= '0;
      r_x1  <= '0;
      r_y1  <= '0;
      r_h   <= '0;
      r_v   <= '0;
      r_red <= '0;
      r_grn <= '0;
      r_blu <= '0;
    end else begin
      if (w_accept) begin
        r_x0  <= cmd_x0;
        r_y0  <= cmd_y0;
        r_x1  <= cmd_x1;
        r_y1  <= cmd_y1;
        r_red <= cmd_R;
        r_grn <= cmd_G;
        r_blu <= cmd_B;
      end
      if (r_state == ST_CLIP) begin
        r_x1 <= w_x1c;
        r_y1 <= w_y1c;
        if (!w_empty && !abort) begin
          r_h <= r_x0;
          r_v <= r_y0;
        end
      end
      // The final write leaves the coordinates on the last pixel
      if (write_en && !abort && !w_last) begin
        if (!w_row_end) begin
          r_h <= r_h + H_WIDTH'(1);
        end else begin
          r_h <= r_x0;
          r_v <= r_v + V_WIDTH'(1);
        end
      end
    end
  end

  assign h_pixel = r_h;
  assign v_pixel = r_v;
  assign R_out   = r_red;
  assign G_out   = r_grn;
  assign B_out   = r_blu;

endmodule
`default_nettype wire

// File: tb/tb_reflet_vga_rect_fill.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reflet_vga_rect_fill
//  Description : Scoreboard bench for the rectangle filler. One instance runs
//                at write interval 1, a second at interval 64.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reflet_vga_rect_fill;

  localparam int CD = 2;
  localparam int HW = 7;
  localparam int VW = 6;

  typedef struct packed {
    logic [HW-1:0] x;
    logic [VW-1:0] y;
    logic [CD-1:0] r;
    logic [CD-1:0] g;
    logic [CD-1:0] b;
  } pix_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid_a, cmd_valid_b;
  logic [HW-1:0] cmd_x0, cmd_x1;
  logic [VW-1:0] cmd_y0, cmd_y1;
  logic [CD-1:0] cmd_r, cmd_g, cmd_b;
  logic          abort_a;
  logic          abort_b;

  logic          rdy_a, busy_a, we_a;
  logic [HW-1:0] h_a;
  logic [VW-1:0] v_a;
  logic [CD-1:0] r_a, g_a, b_a;
  logic          rdy_b, busy_b, we_b;
  logic [HW-1:0] h_b;
  logic [VW-1:0] v_b;
  logic [CD-1:0] r_b, g_b, b_b;

  int   checks   = 0;
  int   failures = 0;
  int   cycle    = 0;
  int   writes_a = 0;
  int   writes_b = 0;
  pix_t exp_q[$];
  int   wcyc_a[$];
  int   wcyc_b[$];
  pix_t wpix_b[$];
  pix_t got_a;
  pix_t exp_a;

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  reflet_vga_rect_fill #(.WRITE_INTERVAL(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid_a), .cmd_ready(rdy_a),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
    .cmd_R(cmd_r), .cmd_G(cmd_g), .cmd_B(cmd_b), .abort(abort_a),
    .busy(busy_a), .write_en(we_a), .h_pixel(h_a), .v_pixel(v_a),
    .R_out(r_a), .G_out(g_a), .B_out(b_a)
  );

  reflet_vga_rect_fill #(.WRITE_INTERVAL(64)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid_b), .cmd_ready(rdy_b),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
    .cmd_R(cmd_r), .cmd_G(cmd_g), .cmd_B(cmd_b), .abort(abort_b),
    .busy(busy_b), .write_en(we_b), .h_pixel(h_b), .v_pixel(v_b),
    .R_out(r_b), .G_out(g_b), .B_out(b_b)
  );

  // Scoreboard for instance A: every write must match the next expected pixel
  always @(negedge clk) begin
    if (we_a === 1'b1) begin
      writes_a = writes_a + 1;
      wcyc_a.push_back(cycle);
      got_a = {h_a, v_a, r_a, g_a, b_a};
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        failures = failures + 1;
        $display("FAIL write_a_unexpected: got (%0d,%0d) rgb %0d/%0d/%0d, none expected",
                 h_a, v_a, r_a, g_a, b_a);
      end else begin
        exp_a = exp_q.pop_front();
        if (got_a !== exp_a) begin
          failures = failures + 1;
          $display("FAIL write_a: got (%0d,%0d) rgb %0d/%0d/%0d expected (%0d,%0d) rgb %0d/%0d/%0d",
                   h_a, v_a, r_a, g_a, b_a, exp_a.x, exp_a.y, exp_a.r, exp_a.g, exp_a.b);
        end
      end
      checks = checks + 1;
      if (h_a >= 7'd80 || v_a >= 6'd60) begin
        failures = failures + 1;
        $display("FAIL write_a_bounds: got (%0d,%0d) required x<80 y<60", h_a, v_a);
      end
    end
  end

  // Instance B write log (timing and colour are checked by its test)
  always @(negedge clk) begin
    if (we_b === 1'b1) begin
      writes_b = writes_b + 1;
      wcyc_b.push_back(cycle);
      wpix_b.push_back({h_b, v_b, r_b, g_b, b_b});
    end
  end

  function automatic void push_exp(input int x, input int y, input int r, input int g, input int b);
    pix_t p;
    p.x = HW'(x);
    p.y = VW'(y);
    p.r = CD'(r);
    p.g = CD'(g);
    p.b = CD'(b);
    exp_q.push_back(p);
  endfunction

  // Present one command for a single cycle; acc is the cycle count at the accepting edge
  task automatic send(input bit to_b, input int x0, input int y0, input int x1, input int y1,
                      input int r, input int g, input int b, output int acc);
    @(negedge clk);
    checks = checks + 1;
    if ((to_b ? rdy_b : rdy_a) !== 1'b1) begin
      failures = failures + 1;
      $display("FAIL send_ready: got %b required 1", to_b ? rdy_b : rdy_a);
    end
    cmd_x0 = HW'(x0);
    cmd_y0 = VW'(y0);
    cmd_x1 = HW'(x1);
    cmd_y1 = VW'(y1);
    cmd_r  = CD'(r);
    cmd_g  = CD'(g);
    cmd_b  = CD'(b);
    if (to_b) cmd_valid_b = 1'b1;
    else      cmd_valid_a = 1'b1;
    @(negedge clk);
    cmd_valid_a = 1'b0;
    cmd_valid_b = 1'b0;
    acc = cycle;
    // Scramble the command bus to show it is ignored after acceptance
    cmd_x0 = 7'd33;
    cmd_y0 = 6'd33;
    cmd_x1 = 7'd1;
    cmd_y1 = 6'd1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks = checks + 1;
    if ({busy_a, we_a, h_a, v_a, r_a, g_a, b_a} !== '0) begin
      failures = failures + 1;
      $display("FAIL reset_outputs: got busy=%b we=%b h=%0d v=%0d rgb=%0d/%0d/%0d required all 0",
               busy_a, we_a, h_a, v_a, r_a, g_a, b_a);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks = checks + 1;
    if (rdy_a !== 1'b1 || rdy_b !== 1'b1 || busy_b !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL reset_ready: got rdy_a=%b rdy_b=%b busy_b=%b required 1 1 0", rdy_a, rdy_b, busy_b);
    end
  endtask

  task automatic test_basic_fill();
    int acc;
    int t;
    wcyc_a.delete();
    writes_a = 0;
    push_exp(2, 3, 2, 1, 0); push_exp(3, 3, 2, 1, 0); push_exp(4, 3, 2, 1, 0);
    push_exp(2, 4, 2, 1, 0); push_exp(3, 4, 2, 1, 0); push_exp(4, 4, 2, 1, 0);
    send(1'b0, 2, 3, 4, 4, 2, 1, 0, acc);
    checks = checks + 1;
    if (busy_a !== 1'b1) begin
      failures = failures + 1;
      $display("FAIL basic_busy_clip: got %b required 1", busy_a);
    end
    t = 0;
    while (busy_a === 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    checks = checks + 1;
    if (cycle !== acc + 7) begin
      failures = failures + 1;
      $display("FAIL basic_busy_drop: got cycle %0d required %0d", cycle, acc + 7);
    end
    checks = checks + 1;
    if (writes_a !== 6) begin
      failures = failures + 1;
      $display("FAIL basic_count: got %0d required 6", writes_a);
    end else begin
      checks = checks + 1;
      if (wcyc_a[0] !== acc + 1 || wcyc_a[5] !== acc + 6) begin
        failures = failures + 1;
        $display("FAIL basic_timing: got first %0d last %0d required %0d %0d",
                 wcyc_a[0], wcyc_a[5], acc + 1, acc + 6);
      end
    end
    checks = checks + 1;
    if (rdy_a !== 1'b1 || exp_q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL basic_end: got ready=%b pending=%0d required 1 0", rdy_a, exp_q.size());
    end
  endtask

  task automatic test_clip();
    int acc;
    int t;
    writes_a = 0;
    push_exp(78, 58, 1, 2, 3); push_exp(79, 58, 1, 2, 3);
    push_exp(78, 59, 1, 2, 3); push_exp(79, 59, 1, 2, 3);
    // 63 is the largest bottom row the 6-bit port can express
    send(1'b0, 78, 58, 100, 63, 1, 2, 3, acc);
    t = 0;
    while (busy_a === 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    checks = checks + 1;
    if (writes_a !== 4 || exp_q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL clip_count: got %0d writes pending=%0d required 4 0", writes_a, exp_q.size());
    end
  endtask

  task automatic test_empty();
    int acc;
    writes_a = 0;
    send(1'b0, 5, 5, 4, 9, 3, 3, 3, acc);
    checks = checks + 1;
    if (busy_a !== 1'b1) begin
      failures = failures + 1;
      $display("FAIL empty_inv_busy: got %b required 1", busy_a);
    end
    @(negedge clk);
    checks = checks + 1;
    if (busy_a !== 1'b0 || rdy_a !== 1'b1) begin
      failures = failures + 1;
      $display("FAIL empty_inv_idle: got busy=%b ready=%b required 0 1", busy_a, rdy_a);
    end
    send(1'b0, 90, 0, 95, 0, 3, 3, 3, acc);
    checks = checks + 1;
    if (busy_a !== 1'b1) begin
      failures = failures + 1;
      $display("FAIL empty_off_busy: got %b required 1", busy_a);
    end
    @(negedge clk);
    checks = checks + 1;
    if (busy_a !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL empty_off_idle: got busy=%b required 0", busy_a);
    end
    repeat (3) @(negedge clk);
    checks = checks + 1;
    if (writes_a !== 0) begin
      failures = failures + 1;
      $display("FAIL empty_writes: got %0d required 0", writes_a);
    end
  endtask

  task automatic test_interval();
    int acc;
    int t;
    wcyc_b.delete();
    wpix_b.delete();
    writes_b = 0;
    send(1'b1, 0, 0, 1, 0, 3, 3, 3, acc);
    t = 0;
    while (busy_b === 1'b1 && t < 400) begin
      @(negedge clk);
      t++;
    end
    checks = checks + 1;
    if (writes_b !== 2) begin
      failures = failures + 1;
      $display("FAIL interval_count: got %0d required 2", writes_b);
    end else begin
      checks = checks + 1;
      if (wcyc_b[0] !== acc + 1 || wcyc_b[1] - wcyc_b[0] !== 64) begin
        failures = failures + 1;
        $display("FAIL interval_spacing: got first %0d gap %0d required %0d 64",
                 wcyc_b[0], wcyc_b[1] - wcyc_b[0], acc + 1);
      end
      checks = checks + 1;
      if (wpix_b[0] !== {7'd0, 6'd0, 6'b111111} || wpix_b[1] !== {7'd1, 6'd0, 6'b111111}) begin
        failures = failures + 1;
        $display("FAIL interval_pixels: got %h %h required (0,0) (1,0) rgb 11", wpix_b[0], wpix_b[1]);
      end
    end
    checks = checks + 1;
    if (busy_b !== 1'b0 || cycle !== acc + 66) begin
      failures = failures + 1;
      $display("FAIL interval_idle: got busy=%b cycle %0d required 0 %0d", busy_b, cycle, acc + 66);
    end
  endtask

  task automatic test_abort();
    int acc;
    int t;
    writes_a = 0;
    push_exp(0, 0, 1, 1, 1); push_exp(1, 0, 1, 1, 1); push_exp(2, 0, 1, 1, 1);
    send(1'b0, 0, 0, 9, 0, 1, 1, 1, acc);
    repeat (3) @(negedge clk);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    #1;
    checks = checks + 1;
    if (busy_a !== 1'b0 || we_a !== 1'b0 || writes_a !== 3) begin
      failures = failures + 1;
      $display("FAIL abort_stop: got busy=%b we=%b writes=%0d required 0 0 3", busy_a, we_a, writes_a);
    end
    // Abort while idle blocks acceptance
    @(negedge clk);
    abort_a = 1'b1;
    cmd_valid_a = 1'b1;
    #1;
    checks = checks + 1;
    if (rdy_a !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL abort_idle_ready: got %b required 0", rdy_a);
    end
    @(negedge clk);
    cmd_valid_a = 1'b0;
    abort_a = 1'b0;
    #1;
    checks = checks + 1;
    if (busy_a !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL abort_idle_accept: got busy=%b required 0", busy_a);
    end
    push_exp(5, 1, 2, 0, 1); push_exp(6, 1, 2, 0, 1);
    send(1'b0, 5, 1, 6, 1, 2, 0, 1, acc);
    t = 0;
    while (busy_a === 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    checks = checks + 1;
    if (writes_a !== 5 || exp_q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL abort_next_cmd: got %0d writes pending=%0d required 5 0", writes_a, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_fill();
    int acc;
    int snap;
    push_exp(0, 0, 3, 2, 1); push_exp(1, 0, 3, 2, 1); push_exp(2, 0, 3, 2, 1);
    send(1'b0, 0, 0, 9, 9, 3, 2, 1, acc);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks = checks + 1;
    if ({busy_a, we_a, h_a, v_a, r_a, g_a, b_a} !== '0) begin
      failures = failures + 1;
      $display("FAIL midreset_outputs: got busy=%b we=%b h=%0d v=%0d rgb=%0d/%0d/%0d required all 0",
               busy_a, we_a, h_a, v_a, r_a, g_a, b_a);
    end
    snap = writes_a;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checks = checks + 1;
    if (writes_a !== snap || busy_a !== 1'b0 || rdy_a !== 1'b1 || exp_q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL midreset_quiet: got writes+%0d busy=%b ready=%b pending=%0d required 0 0 1 0",
               writes_a - snap, busy_a, rdy_a, exp_q.size());
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    cmd_valid_a = 1'b0;
    cmd_valid_b = 1'b0;
    abort_a     = 1'b0;
    abort_b     = 1'b0;
    cmd_x0 = '0; cmd_y0 = '0; cmd_x1 = '0; cmd_y1 = '0;
    cmd_r  = '0; cmd_g  = '0; cmd_b  = '0;
    test_reset();
    test_basic_fill();
    test_clip();
    test_empty();
    test_interval();
    test_abort();
    test_reset_mid_fill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion required finish within 1ms");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
